// File: rtl/musa_muldiv_pkg.sv
// musa_muldiv_pkg: shared definitions for the MUSA multiply/divide unit.
//   - MIPS funct codes served by the unit (FUNCT_MULT .. FUNCT_MTLO)
//   - state encoding for the iterative controller
//   - small decode helpers (is_mul, is_div, is_muldiv, is_signed_op)
package musa_muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Controller state type; encodings kept as plain constants so the
    // values stay stable for older tools and waveform decoders.
    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StCalc = 2'd1;
    localparam state_t StFix  = 2'd2;
    localparam state_t StDone = 2'd3;

    function automatic logic is_mul(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
    endfunction

    function automatic logic is_div(input logic [5:0] f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_muldiv(input logic [5:0] f);
        return is_mul(f) || is_div(f);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/musa_muldiv_if.sv
// musa_muldiv_if: request/response bundle between the EX stage and musa_muldiv.
//   master: drives start, func, data_a, data_b; observes busy, done, div_zero,
//           illegal, result.
//   slave : the multiply/divide unit.
interface musa_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [5:0]       func;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             illegal;
    logic [WIDTH-1:0] result;

    modport master (
        output start, func, data_a, data_b,
        input  busy, done, div_zero, illegal, result
    );

    modport slave (
        input  start, func, data_a, data_b,
        output busy, done, div_zero, illegal, result
    );
endinterface

// File: rtl/musa_div_step.sv
// musa_div_step: one combinational restoring-division step.
//   rem_in  : current partial remainder (always < divisor)
//   bit_in  : next dividend bit shifted in
//   divisor : divisor magnitude (non-zero)
//   rem_out : next partial remainder
//   q_bit   : quotient bit produced by this step
module musa_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        // shifted < 2*divisor, so the MSB of diff is exactly the borrow.
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/musa_muldiv.sv
// musa_muldiv: iterative multiply/divide unit with HI/LO registers.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : start/func/data_a/data_b request; busy/done/div_zero/
//                  illegal/result response (result = HI on MFHI, LO on MFLO)
// Build option: MUSA_MULDIV_DIV_EN adds the divider and DIV/DIVU; without it
// DIV/DIVU raise illegal and leave HI/LO untouched.
module musa_muldiv
    import musa_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32  // must match the width of bus
) (
    input logic          clock,
    input logic          reset,
    musa_muldiv_if.slave bus
);
    localparam int unsigned   CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntInit = CntW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;  // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               neg_res_q, neg_res_d;
    logic               div_zero_q, div_zero_d;
    logic               illegal_q, illegal_d;

    logic               busy, accept, op_signed, sign_a, sign_b, div_ok, skip_calc;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, step_next, prod_fix, fix_val;

    assign busy      = (state_q == StCalc) || (state_q == StFix);
    assign accept    = bus.start && !busy;
    assign op_signed = is_signed_op(bus.func);
    assign sign_a    = op_signed && bus.data_a[WIDTH-1];
    assign sign_b    = op_signed && bus.data_b[WIDTH-1];
    assign mag_a     = sign_a ? -bus.data_a : bus.data_a;
    assign mag_b     = sign_b ? -bus.data_b : bus.data_b;

    // Shift-add: add multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right keeping the carry.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + ({1'b0, mcand_q} & {(WIDTH+1){acc_q[0]}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign prod_fix = neg_res_q ? -acc_q : acc_q;

`ifdef MUSA_MULDIV_DIV_EN
    logic               op_div_q, op_div_d;
    logic               dz_q, dz_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   div_rem, quot_fix, rem_fix;
    logic               div_qbit;
    logic [2*WIDTH-1:0] div_next;

    musa_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
        .bit_in  (acc_q[WIDTH-1]),
        .divisor (mcand_q),
        .rem_out (div_rem),
        .q_bit   (div_qbit)
    );

    assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_qbit};
    assign quot_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign div_ok    = is_div(bus.func);
    assign step_next = op_div_q ? div_next : mul_next;
    assign fix_val   = op_div_q ? {rem_fix, quot_fix} : prod_fix;
    // Zero divisor: the first CALC cycle goes straight to FIX without stepping.
    assign skip_calc = dz_q;
`else
    assign div_ok    = 1'b0;
    assign step_next = mul_next;
    assign fix_val   = prod_fix;
    assign skip_calc = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_res_d  = neg_res_q;
        div_zero_d = div_zero_q;
        illegal_d  = 1'b0;
`ifdef MUSA_MULDIV_DIV_EN
        op_div_d   = op_div_q;
        dz_d       = dz_q;
        neg_rem_d  = neg_rem_q;
`endif
        case (state_q)
            StCalc: begin
                if (skip_calc) begin
                    state_d = StFix;
                end else begin
                    acc_d = step_next;
                    if (cnt_q == '0) state_d = StFix;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            StFix: begin
                hi_d    = fix_val[2*WIDTH-1:WIDTH];
                lo_d    = fix_val[WIDTH-1:0];
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: ;
        endcase

        // Requests are taken in IDLE and DONE; DONE acceptance gives back-to-back ops.
        if (accept) begin
            if (is_mul(bus.func) || div_ok) begin
                state_d    = StCalc;
                cnt_d      = CntInit;
                neg_res_d  = sign_a ^ sign_b;
                div_zero_d = 1'b0;
                mcand_d    = mag_a;
                acc_d      = {{WIDTH{1'b0}}, mag_b};
`ifdef MUSA_MULDIV_DIV_EN
                op_div_d   = div_ok;
                dz_d       = 1'b0;
                neg_rem_d  = sign_a;
                if (div_ok) begin
                    mcand_d = mag_b;
                    acc_d   = {{WIDTH{1'b0}}, mag_a};
                    if (bus.data_b == '0) begin
                        dz_d       = 1'b1;
                        div_zero_d = 1'b1;
                        neg_res_d  = 1'b0;
                        neg_rem_d  = 1'b0;
                        acc_d      = {bus.data_a, {WIDTH{1'b1}}};
                    end
                end
`endif
            end else if (bus.func == FUNCT_MTHI) begin
                hi_d = bus.data_a;
            end else if (bus.func == FUNCT_MTLO) begin
                lo_d = bus.data_a;
            end else if ((bus.func != FUNCT_MFHI) && (bus.func != FUNCT_MFLO)) begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_res_q  <= 1'b0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_res_q  <= neg_res_d;
            div_zero_q <= div_zero_d;
            illegal_q  <= illegal_d;
        end
    end

`ifdef MUSA_MULDIV_DIV_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            op_div_q  <= op_div_d;
            dz_q      <= dz_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`endif

    assign bus.busy     = busy;
    assign bus.done     = (state_q == StDone);
    assign bus.div_zero = div_zero_q;
    assign bus.illegal  = illegal_q;

    always_comb begin
        bus.result = '0;
        if (bus.func == FUNCT_MFHI)      bus.result = hi_q;
        else if (bus.func == FUNCT_MFLO) bus.result = lo_q;
    end
endmodule

// File: tb/tb_musa_muldiv.sv
// tb_musa_muldiv: scoreboard bench for musa_muldiv (WIDTH = 32).
// Stimulus pushes expected events (done / illegal / register read) into a
// queue; a negedge monitor pops and compares whenever the DUT presents one.
module tb_musa_muldiv;
    import musa_muldiv_pkg::*;

    localparam int unsigned W = 32;
    localparam int KDone = 0;
    localparam int KRead = 1;
    localparam int KIll  = 2;

    typedef struct {
        int         kind;
        int         tag;
        logic [W-1:0] val;
        logic       dz;
        bit         chk_res;
        int         due;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    bit   rd_strobe = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tag_n = 0;
    ent_t sb[$];

    musa_muldiv_if #(.WIDTH(W)) bus_if ();

    musa_muldiv #(
        .WIDTH (W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [#%0d]: got 0x%0h, want 0x%0h", name, tag, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: observed event does not match scoreboard", name);
    endtask

    // Monitor
    always @(negedge clock) begin
        ent_t e;
        if (!reset) begin
            if (bus_if.done) begin
                if (sb.size() == 0) miss("unexpected_done");
                else begin
                    e = sb.pop_front();
                    check("done_kind", e.tag, e.kind, KDone);
                    check("done_cycle", e.tag, cyc, e.due);
                    check("div_zero", e.tag, bus_if.div_zero, e.dz);
                    if (e.chk_res) check("done_lo", e.tag, bus_if.result, e.val);
                end
            end
            if (bus_if.illegal) begin
                if (sb.size() == 0) miss("unexpected_illegal");
                else begin
                    e = sb.pop_front();
                    check("ill_kind", e.tag, e.kind, KIll);
                    check("ill_cycle", e.tag, cyc, e.due);
                end
            end
            if (rd_strobe) begin
                if (sb.size() == 0) miss("unexpected_read");
                else begin
                    e = sb.pop_front();
                    check("read_kind", e.tag, e.kind, KRead);
                    check("read_val", e.tag, bus_if.result, e.val);
                end
            end
        end
    end

    task automatic push(input int kind, input logic [W-1:0] val, input logic dz,
                        input bit chk, input int due);
        ent_t e;
        e.kind = kind; e.tag = tag_n; e.val = val; e.dz = dz; e.chk_res = chk; e.due = due;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] lo, input logic dz, input bit chk,
                            input int lat);
        tag_n++;
        bus_if.start = 1'b1; bus_if.func = f; bus_if.data_a = a; bus_if.data_b = b;
        push(KDone, lo, dz, chk, cyc + lat);
        tick();
        bus_if.start = 1'b0; bus_if.func = FUNCT_MFLO;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus_if.done && n < 60) begin
            tick();
            n++;
        end
        if (!bus_if.done) miss("done_timeout");
    endtask

    task automatic read_reg(input logic [5:0] f, input logic [W-1:0] exp);
        tag_n++;
        bus_if.func = f; rd_strobe = 1'b1;
        push(KRead, exp, 1'b0, 1'b1, cyc);
        tick();
        rd_strobe = 1'b0;
    endtask

    task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz,
                         input int lat);
        start_op(f, a, b, lo, dz, 1'b1, lat);
        wait_done();
        tick();
        read_reg(FUNCT_MFHI, hi);
        read_reg(FUNCT_MFLO, lo);
    endtask

    task automatic pulse(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        bus_if.start = 1'b1; bus_if.func = f; bus_if.data_a = a; bus_if.data_b = b;
        tick();
        bus_if.start = 1'b0; bus_if.func = FUNCT_MFLO;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_if.start = 1'b0; bus_if.func = FUNCT_MFHI; bus_if.data_a = '0; bus_if.data_b = '0;
        #2;
        check("rst_busy", 0, bus_if.busy, 0);
        check("rst_done", 0, bus_if.done, 0);
        check("rst_div_zero", 0, bus_if.div_zero, 0);
        check("rst_illegal", 0, bus_if.illegal, 0);
        check("rst_result_hi", 0, bus_if.result, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        read_reg(FUNCT_MFHI, 32'h0);
        read_reg(FUNCT_MFLO, 32'h0);

        // MULTU 25x12, with a MULT and an unsupported func offered while busy
        start_op(FUNCT_MULTU, 32'd25, 32'd12, 32'd300, 1'b0, 1'b1, 34);
        repeat (4) tick();
        pulse(FUNCT_MULT, 32'd100, 32'd100);
        repeat (2) tick();
        pulse(6'h3F, 32'd1, 32'd1);
        wait_done();
        tick();
        read_reg(FUNCT_MFHI, 32'h0);
        read_reg(FUNCT_MFLO, 32'd300);
        bus_if.func = FUNCT_MULT;
        #1;
        check("result_non_mf", 0, bus_if.result, 0);

        do_op(FUNCT_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
        do_op(FUNCT_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 34);
        do_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 34);
        do_op(FUNCT_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 34);

        // Back-to-back: second start issued in the DONE cycle of the first
        start_op(FUNCT_MULTU, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 34);
        wait_done();
        start_op(FUNCT_MULT, 32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFF6, 1'b0, 1'b1, 34);
        wait_done();
        tick();
        read_reg(FUNCT_MFHI, 32'hFFFF_FFFF);
        read_reg(FUNCT_MFLO, 32'hFFFF_FFF6);

        // Unsupported func
        tag_n++;
        push(KIll, '0, 1'b0, 1'b0, cyc + 1);
        pulse(6'h20, 32'd1, 32'd2);
        tick();

`ifdef MUSA_MULDIV_DIV_EN
        do_op(FUNCT_DIVU, 32'd25,        32'd12,        32'd1,         32'd2,         1'b0, 34);
        do_op(FUNCT_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        do_op(FUNCT_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 34);
        do_op(FUNCT_DIV,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 3);
        check("div_zero_sticky", 0, bus_if.div_zero, 1);
        do_op(FUNCT_MULT, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 34);
        do_op(FUNCT_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 34);
`endif

        // Moves
        pulse(FUNCT_MTHI, 32'hDEAD_BEEF, 32'd0);
        read_reg(FUNCT_MFHI, 32'hDEAD_BEEF);
        pulse(FUNCT_MTLO, 32'h1234_5678, 32'd0);
        read_reg(FUNCT_MFLO, 32'h1234_5678);

`ifndef MUSA_MULDIV_DIV_EN
        // Divider absent: DIVU is rejected and leaves HI/LO alone
        tag_n++;
        push(KIll, '0, 1'b0, 1'b0, cyc + 1);
        pulse(FUNCT_DIVU, 32'd25, 32'd12);
        check("nodiv_busy", tag_n, bus_if.busy, 0);
        check("nodiv_div_zero", tag_n, bus_if.div_zero, 0);
        tick();
        read_reg(FUNCT_MFHI, 32'hDEAD_BEEF);
        read_reg(FUNCT_MFLO, 32'h1234_5678);
`endif

        // Reset in the middle of a MULT
        pulse(FUNCT_MULT, 32'd9, 32'd9);
        repeat (9) tick();
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 0, bus_if.busy, 0);
        check("rst_mid_done", 0, bus_if.done, 0);
        tick();
        reset = 1'b0;
        tick();
        read_reg(FUNCT_MFHI, 32'h0);
        read_reg(FUNCT_MFLO, 32'h0);
        repeat (40) tick();

        check("queue_empty", 0, sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
